// File: rtl/fetch_align.sv
// Instruction fetch aligner: word fetches into a 4-halfword buffer, one RVC parcel
// or 32-bit (possibly word-straddling) instruction handed to decode per handshake.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_rvc
);

  logic [3:0][15:0] hbuf_q, hbuf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      head_pc_q, head_pc_d;
  logic             skip_low_q, skip_low_d;

  logic        head_rvc, have_instr, accept, xfer;
  logic [1:0]  pop, push;
  logic [2:0]  rem;
  logic [15:0] p0, p1;

  assign head_rvc   = hbuf_q[0][1:0] != 2'b11;
  assign have_instr = head_rvc ? (cnt_q >= 3'd1) : (cnt_q >= 3'd2);

  // Gate on the pre-pop count so a full pop+push can never overflow the buffer.
  assign mem_valid = !reset && !flush && (cnt_q <= 3'd2);
  assign mem_addr  = fetch_addr_q;
  assign out_valid = have_instr && !flush && !reset;
  assign out_rvc   = head_rvc && (cnt_q != 3'd0);
  assign out_instr = head_rvc ? {16'h0, hbuf_q[0]} : {hbuf_q[1], hbuf_q[0]};
  assign out_pc    = head_pc_q;

  assign accept = mem_valid && mem_ready;
  assign xfer   = out_valid && out_ready;
  assign pop    = xfer ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign push   = accept ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
  assign rem    = cnt_q - {1'b0, pop};
  assign p0     = skip_low_q ? mem_rdata[31:16] : mem_rdata[15:0];
  assign p1     = mem_rdata[31:16];

  // Survivors slide to the head, then the new halfwords append behind them.
  always_comb begin
    hbuf_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < rem)
        hbuf_d[i] = hbuf_q[2'(i) + pop];
      else if (3'(i) == rem && push != 2'd0)
        hbuf_d[i] = p0;
      else if (3'(i) == rem + 3'd1 && push == 2'd2)
        hbuf_d[i] = p1;
    end
  end

  always_comb begin
    cnt_d        = rem + {1'b0, push};
    head_pc_d    = head_pc_q + {29'h0, pop, 1'b0};
    fetch_addr_d = accept ? fetch_addr_q + 32'd4 : fetch_addr_q;
    skip_low_d   = accept ? 1'b0 : skip_low_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hbuf_q       <= '0;
      cnt_q        <= '0;
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= RESET_PC & ~32'h3;
      skip_low_q   <= RESET_PC[1];
    end else if (flush) begin
      cnt_q        <= '0;
      head_pc_q    <= flush_pc & ~32'h1;
      fetch_addr_q <= flush_pc & ~32'h3;
      skip_low_q   <= flush_pc[1];
    end else begin
      hbuf_q       <= hbuf_d;
      cnt_q        <= cnt_d;
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_low_q   <= skip_low_d;
    end
  end

endmodule
